// File: rtl/irq_ctrl_n_if.sv
// Register bus and CPU interrupt handshake between riscv_multicyc/mmapper and irq_ctrl_n.
// The CPU side is the master; the interrupt controller is the slave.
interface irq_ctrl_n_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        eip;
    logic        eip_istimer;
    logic        eip_reply;

    modport master (
        output a, d, we, eip_reply,
        input  spo, eip, eip_istimer
    );

    modport slave (
        input  a, d, we, eip_reply,
        output spo, eip, eip_istimer
    );
endinterface

// File: rtl/irq_ctrl_n.sv
// Parametrised interrupt controller: synchronised level/edge sources, fixed priority
// (lowest index wins) and a request/acknowledge/complete handshake with the CPU.
module irq_ctrl_n #(
    parameter int                   NUM_SRC   = 8,
    parameter int                   TIMER_SRC = 0,
    parameter logic [NUM_SRC-1:0]   EDGE_RST  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src,
    irq_ctrl_n_if.slave        bus
);

    localparam int         PAD      = 32 - NUM_SRC;
    localparam logic [4:0] TIMER_ID = 5'(TIMER_SRC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [4:0]         claim_q, claim_d;

    logic [NUM_SRC-1:0] req, edge_det, win_onehot, claim_clr, clr;
    logic [4:0]         winner;
    logic               wr_pend, wr_en, wr_edge, wr_claim;
    logic               eip_w, istimer_w;

    assign wr_pend  = bus.we && (bus.a == 3'd0);
    assign wr_en    = bus.we && (bus.a == 3'd1);
    assign wr_edge  = bus.we && (bus.a == 3'd2);
    assign wr_claim = bus.we && (bus.a == 3'd3);

    assign req      = pend_q & en_q;
    assign edge_det = s2_q & ~s3_q;

    // Descending scan so the lowest set index is the last assignment and wins.
    always_comb begin
        winner     = '0;
        win_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner     = 5'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        claim_d   = claim_q;
        claim_clr = '0;
        eip_w     = 1'b0;
        istimer_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                eip_w     = 1'b1;
                istimer_w = (|req) && (winner == 5'(TIMER_SRC));
                if (!(|req)) begin
                    state_d = ST_IDLE;
                end else if (bus.eip_reply) begin
                    claim_d   = winner + 5'd1;
                    claim_clr = win_onehot;
                    state_d   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                istimer_w = (claim_q == TIMER_ID);
                // A completion write takes precedence over a stray acknowledge.
                if (wr_claim) begin
                    claim_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge bits: a new edge beats a clear in the same cycle. Level bits mirror s2.
    always_comb begin
        clr    = claim_clr | (wr_pend ? bus.d[NUM_SRC-1:0] : '0);
        pend_d = (edge_q & ((pend_q & ~clr) | edge_det)) | (~edge_q & s2_q);
        en_d   = wr_en   ? bus.d[NUM_SRC-1:0] : en_q;
        edge_d = wr_edge ? bus.d[NUM_SRC-1:0] : edge_q;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            edge_q  <= EDGE_RST;
            claim_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= src;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            en_q    <= en_d;
            edge_q  <= edge_d;
            claim_q <= claim_d;
        end
    end

    always_comb begin
        bus.spo = '0;
        case (bus.a)
            3'd0:    bus.spo = {{PAD{1'b0}}, pend_q};
            3'd1:    bus.spo = {{PAD{1'b0}}, en_q};
            3'd2:    bus.spo = {{PAD{1'b0}}, edge_q};
            3'd3:    bus.spo = {27'd0, claim_q};
            3'd4:    bus.spo = {29'd0, state_q, eip_w};
            default: bus.spo = '0;
        endcase
    end

    assign bus.eip         = eip_w;
    assign bus.eip_istimer = istimer_w;

endmodule
